// File: rtl/seqdet_pkg.sv
// Shared types and elaboration-time helpers for the multi-channel pattern detector.
// Optional per-channel match counters are enabled with SEQDET_MATCH_CNT_EN.
package seqdet_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    function automatic int prog_w(input int plen);
        return (plen <= 2) ? 1 : $clog2(plen);
    endfunction

    // Bit j of the pattern in arrival order (j = 0 is the first bit received).
    function automatic logic pbit(input logic [7:0] pat, input int plen,
                                  input int j);
        logic [7:0] t;
        t = pat >> (plen - 1 - j);
        return t[0];
    endfunction

    // Failure function: longest proper border of the first k pattern bits.
    function automatic int border(input logic [7:0] pat, input int plen,
                                  input int k);
        int r;
        logic ok;
        r = 0;
        for (int m = 1; m < k; m++) begin
            ok = 1'b1;
            for (int j = 0; j < m; j++)
                if (pbit(pat, plen, k - m + j) != pbit(pat, plen, j))
                    ok = 1'b0;
            if (ok)
                r = m;
        end
        return r;
    endfunction

    // Longest pattern prefix that ends the matched prefix p extended by b.
    function automatic int step_next(input logic [7:0] pat, input int plen,
                                     input int p, input logic b);
        int r;
        logic ok;
        logic sb;
        r = 0;
        for (int k = 1; k <= p + 1; k++) begin
            ok = 1'b1;
            for (int j = 0; j < k; j++) begin
                sb = (p + 1 - k + j < p) ? pbit(pat, plen, p + 1 - k + j) : b;
                if (sb != pbit(pat, plen, j))
                    ok = 1'b0;
            end
            if (ok)
                r = k;
        end
        return r;
    endfunction

endpackage

// File: rtl/seqdet_step.sv
// Shared detector step: (progress, bit) -> (next progress, hit).
// Built as a constant lookup table so the datapath is a single mux.
module seqdet_step
    import seqdet_pkg::*;
#(
    parameter int              PLEN    = 4,
    parameter logic [PLEN-1:0] PATTERN = 4'b1010,
    localparam int             PW      = prog_w(PLEN)
) (
    input  logic [PW-1:0] i_p,
    input  logic          i_b,
    output logic [PW-1:0] o_p,
    output logic          o_hit
);

    localparam logic [7:0] PAT8 = 8'(PATTERN);
    localparam int         NENT = 2 ** (PW + 1);
    localparam int         BRD  = border(PAT8, PLEN, PLEN);

    logic [PW-1:0]   w_nxt [NENT];
    logic [NENT-1:0] w_hit;

    for (genvar i = 0; i < NENT; i++) begin : g_tab
        localparam int N = ((i / 2) < PLEN) ?
            step_next(PAT8, PLEN, i / 2, (i % 2) == 1) : 0;
        assign w_nxt[i] = PW'((N == PLEN) ? BRD : N);
        assign w_hit[i] = (N == PLEN);
    end

    assign o_p   = w_nxt[{i_p, i_b}];
    assign o_hit = w_hit[{i_p, i_b}];

endmodule

// File: rtl/seqdet_rr_scheduler.sv
// Round-robin scheduler sharing one pattern-detector step across NCH channels.
// Define SEQDET_MATCH_CNT_EN to add saturating per-channel match counters.
module seqdet_rr_scheduler
    import seqdet_pkg::*;
#(
    parameter int              NCH     = 4,
    parameter int              PLEN    = 4,
    parameter logic [PLEN-1:0] PATTERN = 4'b1010,
    parameter int              CNT_W   = 8,
    localparam int             CHW     = $clog2(NCH),
    localparam int             PW      = prog_w(PLEN)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] req_valid,
    input  logic [NCH-1:0] req_bit,
    output logic [NCH-1:0] req_ready,
    input  logic           flush,
    output logic           busy,
    output logic           match_valid,
    output logic [CHW-1:0] match_ch
`ifdef SEQDET_MATCH_CNT_EN
    ,
    input  logic [CHW-1:0]   cnt_rd_ch,
    output logic [CNT_W-1:0] cnt_rd_data
`endif
);

    localparam logic [CHW-1:0] LAST  = CHW'(NCH - 1);
    localparam logic [CHW:0]   NCH_V = (CHW + 1)'(NCH);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CHW-1:0] r_rr;
    logic [CHW-1:0] r_idx;
    logic [PW-1:0]  r_prog [NCH];
    logic           r_mv;
    logic [CHW-1:0] r_mch;

    logic [NCH-1:0] w_gnt;
    logic [CHW-1:0] w_gidx;
    logic           w_any;
    logic [CHW:0]   w_j;
    logic           w_xfer;
    logic [PW-1:0]  w_p_nxt;
    logic           w_hit;

    // Cyclic priority search starting at the round-robin pointer.
    always_comb begin
        w_any  = 1'b0;
        w_gidx = '0;
        w_j    = '0;
        for (int k = 0; k < NCH; k++) begin
            w_j = {1'b0, r_rr} + (CHW + 1)'(k);
            if (w_j >= NCH_V)
                w_j = w_j - NCH_V;
            if (!w_any && req_valid[w_j[CHW-1:0]]) begin
                w_any  = 1'b1;
                w_gidx = w_j[CHW-1:0];
            end
        end
        w_gnt         = '0;
        w_gnt[w_gidx] = w_any;
    end

    assign w_xfer = (r_state == RUN) && !flush && w_any;

    seqdet_step #(
        .PLEN    (PLEN),
        .PATTERN (PATTERN)
    ) u_step (
        .i_p   (r_prog[w_gidx]),
        .i_b   (req_bit[w_gidx]),
        .o_p   (w_p_nxt),
        .o_hit (w_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= RUN;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            RUN:     if (flush) w_state_nxt = FLUSH;
            FLUSH:   if (r_idx == LAST) w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_comb begin
        req_ready = '0;
        busy      = 1'b0;
        unique case (r_state)
            RUN:     if (!flush) req_ready = w_gnt;
            FLUSH:   busy = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr  <= '0;
            r_idx <= '0;
            r_mv  <= 1'b0;
            r_mch <= '0;
            for (int i = 0; i < NCH; i++)
                r_prog[i] <= '0;
        end else begin
            r_mv <= 1'b0;
            if (r_state == FLUSH) begin
                r_prog[r_idx] <= '0;
                r_idx         <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
            end else if (flush) begin
                r_idx <= '0;
            end else if (w_xfer) begin
                r_prog[w_gidx] <= w_p_nxt;
                r_rr           <= (w_gidx == LAST) ? '0 : w_gidx + 1'b1;
                r_mv           <= w_hit;
                if (w_hit)
                    r_mch <= w_gidx;
            end
        end
    end

    assign match_valid = r_mv;
    assign match_ch    = r_mch;

`ifdef SEQDET_MATCH_CNT_EN
    logic [CNT_W-1:0] r_cnt [NCH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++)
                r_cnt[i] <= '0;
        end else if (r_state == RUN && flush) begin
            for (int i = 0; i < NCH; i++)
                r_cnt[i] <= '0;
        end else if (w_xfer && w_hit && r_cnt[w_gidx] != '1) begin
            r_cnt[w_gidx] <= r_cnt[w_gidx] + 1'b1;
        end
    end

    assign cnt_rd_data = r_cnt[cnt_rd_ch];
`else
    // Width only matters when counters are built; keep it referenced.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_seqdet_rr_scheduler.sv
// Self-checking bench: sliding-window reference model plus directed scenarios.
// Build with SEQDET_MATCH_CNT_EN to also exercise the match counters.
module tb_seqdet_rr_scheduler;

    localparam int         NCH  = 4;
    localparam int         PLEN = 4;
    localparam int         CHW  = 2;
    localparam logic [3:0] PAT  = 4'b1010;
`ifdef SEQDET_MATCH_CNT_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 8;
`endif

    logic           clk;
    logic           rst;
    logic [NCH-1:0] req_valid;
    logic [NCH-1:0] req_bit;
    logic [NCH-1:0] req_ready;
    logic           flush;
    logic           busy;
    logic           match_valid;
    logic [CHW-1:0] match_ch;
`ifdef SEQDET_MATCH_CNT_EN
    logic [CHW-1:0]   cnt_rd_ch;
    logic [CNT_W-1:0] cnt_rd_data;
`endif

    seqdet_rr_scheduler #(
        .NCH     (NCH),
        .PLEN    (PLEN),
        .PATTERN (PAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_bit     (req_bit),
        .req_ready   (req_ready),
        .flush       (flush),
        .busy        (busy),
        .match_valid (match_valid),
        .match_ch    (match_ch)
`ifdef SEQDET_MATCH_CNT_EN
        ,
        .cnt_rd_ch   (cnt_rd_ch),
        .cnt_rd_data (cnt_rd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Reference model: each channel keeps its recent bit history; a hit is
    // simply "the last PLEN bits since the last clear equal the pattern".
    int             m_rr;
    int             m_busy;
    logic [PLEN-1:0] m_hist [NCH];
    int             m_len  [NCH];
    logic           m_mv;
    int             m_mch;
    int             m_cnt  [NCH];

    function automatic int pick(input logic [NCH-1:0] v);
        int r;
        int c;
        r = -1;
        for (int k = 0; k < NCH; k++) begin
            c = (m_rr + k) % NCH;
            if (r < 0 && v[c])
                r = c;
        end
        return r;
    endfunction

    always @(posedge clk or posedge rst) begin : model
        int g;
        if (rst) begin
            m_rr   = 0;
            m_busy = 0;
            m_mv   = 1'b0;
            m_mch  = 0;
            for (int i = 0; i < NCH; i++) begin
                m_hist[i] = '0;
                m_len[i]  = 0;
                m_cnt[i]  = 0;
            end
        end else if (m_busy > 0) begin
            m_busy = m_busy - 1;
            m_mv   = 1'b0;
        end else if (flush) begin
            m_busy = NCH;
            m_mv   = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                m_hist[i] = '0;
                m_len[i]  = 0;
                m_cnt[i]  = 0;
            end
        end else begin
            g = pick(req_valid);
            if (g < 0) begin
                m_mv = 1'b0;
            end else begin
                m_hist[g] = {m_hist[g][PLEN-2:0], req_bit[g]};
                m_len[g]  = m_len[g] + 1;
                m_mv      = (m_len[g] >= PLEN) && (m_hist[g] == PAT);
                if (m_mv) begin
                    m_mch = g;
                    if (m_cnt[g] < (1 << CNT_W) - 1)
                        m_cnt[g] = m_cnt[g] + 1;
                end
                m_rr = (g + 1) % NCH;
            end
        end
    end

    always @(negedge clk) begin : compare
        int g;
        int er;
        if (!rst) begin
            g  = pick(req_valid);
            er = (m_busy > 0 || flush || g < 0) ? 0 : (1 << g);
            chk("req_ready", req_ready, er);
            chk("busy", busy, m_busy > 0);
            chk("match_valid", match_valid, m_mv);
            chk("match_ch", match_ch, m_mch);
`ifdef SEQDET_MATCH_CNT_EN
            chk("cnt_rd_data", cnt_rd_data, m_cnt[cnt_rd_ch]);
`endif
        end
    end

    // Called at posedge+1; returns at the next posedge+1. -1 skips a check.
    task automatic step(input logic [NCH-1:0] v, input logic [NCH-1:0] b,
                        input logic f, input int e_rdy, input int e_busy,
                        input int e_mv);
        req_valid = v;
        req_bit   = b;
        flush     = f;
        #3;
        if (e_rdy >= 0)
            chk("step_ready", req_ready, e_rdy);
        if (e_busy >= 0)
            chk("step_busy", busy, e_busy);
        @(posedge clk);
        #1;
        if (e_mv >= 0)
            chk("step_match", match_valid, e_mv);
        flush = 1'b0;
    endtask

    task automatic sendc(input int ch, input logic bt, input int e_mv);
        logic [NCH-1:0] v;
        logic [NCH-1:0] b;
        v = '0;
        b = '0;
        v[ch] = 1'b1;
        b[ch] = bt;
        step(v, b, 1'b0, int'(v), 0, e_mv);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        flush     = 1'b0;
        #1;
        chk("rst_match_valid", match_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_match_ch", match_ch, 0);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [5:0] s1b;
        logic [5:0] s1e;
        logic [3:0] pv;
        logic [NCH-1:0] b;
        rst       = 1'b1;
        req_valid = '0;
        req_bit   = '0;
        flush     = 1'b0;
`ifdef SEQDET_MATCH_CNT_EN
        cnt_rd_ch = '0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("init_match_valid", match_valid, 0);
        chk("init_busy", busy, 0);
        chk("init_match_ch", match_ch, 0);
        chk("init_ready", req_ready, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Overlapping hits on one channel.
        s1b = 6'b101010;
        s1e = 6'b000101;
        for (int i = 0; i < 6; i++)
            sendc(0, s1b[5 - i], int'(s1e[5 - i]));
        chk("s1_ch", match_ch, 0);

        // All channels valid: strict rotation, only ch2 carries the pattern.
        do_reset();
        pv = PAT;
        for (int k = 0; k < 16; k++) begin
            b    = '0;
            b[2] = pv[3 - (k / 4)];
            step('1, b, 1'b0, 1 << (k % 4), 0, (k == 14) ? 1 : 0);
        end
        chk("s2_ch", match_ch, 2);

        // Saved progress survives another channel's traffic.
        do_reset();
        sendc(1, 1'b1, 0);
        sendc(1, 1'b0, 0);
        sendc(1, 1'b1, 0);
        for (int i = 0; i < 4; i++)
            sendc(3, 1'b0, 0);
        sendc(1, 1'b0, 1);
        chk("s3_ch", match_ch, 1);

        // Flush beats a transfer, lasts NCH cycles, ignores a second pulse.
        do_reset();
        sendc(0, 1'b1, 0);
        sendc(0, 1'b0, 0);
        sendc(0, 1'b1, 0);
        step(4'b0001, '0, 1'b1, 0, 0, 0);
        for (int i = 0; i < 4; i++)
            step(4'b0001, '0, i == 1, 0, 1, 0);
        step(4'b0001, '0, 1'b0, 1, 0, 0);

        // Reset mid-pattern and mid-flush.
        do_reset();
        sendc(1, 1'b1, 0);
        sendc(1, 1'b0, 0);
        sendc(1, 1'b1, 0);
        sendc(1, 1'b0, 1);
        chk("s5_ch_before", match_ch, 1);
        sendc(0, 1'b1, 0);
        sendc(0, 1'b0, 0);
        sendc(0, 1'b1, 0);
        do_reset();
        sendc(0, 1'b0, 0);
        sendc(0, 1'b1, 0);
        sendc(0, 1'b0, 0);
        sendc(0, 1'b1, 0);
        sendc(0, 1'b0, 1);
        step('0, '0, 1'b1, 0, 0, 0);
        step('0, '0, 1'b0, 0, 1, 0);
        do_reset();
        step('0, '0, 1'b0, 0, 0, 0);

`ifdef SEQDET_MATCH_CNT_EN
        // Five hits saturate a 2-bit counter; flush clears it.
        do_reset();
        cnt_rd_ch = '0;
        for (int i = 0; i < 12; i++)
            sendc(0, (i % 2) == 0, -1);
        chk("cnt_sat", cnt_rd_data, 3);
        step('0, '0, 1'b1, 0, 0, 0);
        chk("cnt_flush", cnt_rd_data, 0);
        repeat (4) step('0, '0, 1'b0, -1, -1, -1);
`endif

        // Randomized traffic checked cycle by cycle against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
`ifdef SEQDET_MATCH_CNT_EN
            cnt_rd_ch = CHW'($urandom_range(0, NCH - 1));
`endif
            if ($urandom_range(0, 499) == 0)
                do_reset();
            else
                step(NCH'($urandom & $urandom), NCH'($urandom),
                     $urandom_range(0, 63) == 0, -1, -1, -1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
